// File: rtl/mem_coherence_responder.sv
// Memory-side responder for a snooping MSI-style coherence bus: tracks per-line
// memory state and owner, answers GETS/GETM/PUTM and absorbs owner write-backs.
module mem_coherence_responder #(
  parameter  int NUM_CACHE      = 8,
  parameter  int XLEN           = 32,
  parameter  int CACHELINE_SIZE = 8,
  parameter  int NUM_LINES      = 4,
  localparam int SW             = $clog2(NUM_CACHE) + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [SW-1:0]             req_source,
  input  logic [XLEN-1:0]           req_addr,
  input  logic [1:0]                req_bus_tx,
  input  logic                      wb_valid,
  input  logic                      wb_memory_flag,
  input  logic [SW-1:0]             wb_source,
  input  logic [XLEN-1:0]           wb_addr,
  input  logic [CACHELINE_SIZE-1:0] wb_data,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [SW-1:0]             resp_destination,
  output logic [XLEN-1:0]           resp_addr,
  output logic [CACHELINE_SIZE-1:0] resp_data,
  output logic [1:0]                resp_mmsg
);

  localparam int IW = $clog2(NUM_LINES);

  localparam logic [1:0] TX_GETS = 2'd0;
  localparam logic [1:0] TX_GETM = 2'd1;
  localparam logic [1:0] TX_PUTM = 2'd2;

  localparam logic [1:0] MSG_EXCLUSIVE = 2'd0;
  localparam logic [1:0] MSG_DATA      = 2'd1;
  localparam logic [1:0] MSG_NODATA    = 2'd2;
  localparam logic [1:0] MSG_NODATAE   = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_RESP, ST_WAIT_WB} fsm_state_t;
  typedef enum logic [2:0] {LS_MI, LS_MS, LS_MEORM, LS_MSD, LS_MID, LS_MEORMD} line_state_t;

  fsm_state_t                state_q, state_d;
  line_state_t               line_state_q [NUM_LINES];
  line_state_t               line_state_d [NUM_LINES];
  logic [SW-1:0]             owner_q      [NUM_LINES];
  logic [SW-1:0]             owner_d      [NUM_LINES];
  logic [CACHELINE_SIZE-1:0] data_q       [NUM_LINES];
  logic [CACHELINE_SIZE-1:0] data_d       [NUM_LINES];

  logic                      resp_valid_q, resp_valid_d;
  logic [SW-1:0]             resp_dest_q, resp_dest_d;
  logic [XLEN-1:0]           resp_addr_q, resp_addr_d;
  logic [CACHELINE_SIZE-1:0] resp_data_q, resp_data_d;
  logic [1:0]                resp_mmsg_q, resp_mmsg_d;
  logic [XLEN-1:0]           wait_addr_q, wait_addr_d;
  logic [SW-1:0]             wait_src_q, wait_src_d;

  logic [IW-1:0] req_idx;
  logic [IW-1:0] wait_idx;
  logic          wb_match;
  logic          any_meormd;

  assign req_idx  = req_addr[IW-1:0];
  assign wait_idx = wait_addr_q[IW-1:0];
  assign wb_match = wb_valid && wb_memory_flag && (wb_source == wait_src_q)
                    && (wb_addr == wait_addr_q);

  // Ready is forced low while reset is asserted, not just after the next edge.
  assign req_ready        = (state_q == ST_IDLE) && rst_n;
  assign resp_valid       = resp_valid_q;
  assign resp_destination = resp_dest_q;
  assign resp_addr        = resp_addr_q;
  assign resp_data        = resp_data_q;
  assign resp_mmsg        = resp_mmsg_q;

  always_comb begin
    state_d      = state_q;
    line_state_d = line_state_q;
    owner_d      = owner_q;
    data_d       = data_q;
    resp_valid_d = resp_valid_q;
    resp_dest_d  = resp_dest_q;
    resp_addr_d  = resp_addr_q;
    resp_data_d  = resp_data_q;
    resp_mmsg_d  = resp_mmsg_q;
    wait_addr_d  = wait_addr_q;
    wait_src_d   = wait_src_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          case (req_bus_tx)
            TX_GETS: begin
              if (line_state_q[req_idx] == LS_MI) begin
                line_state_d[req_idx] = LS_MEORM;
                owner_d[req_idx]      = req_source;
                state_d               = ST_RESP;
                resp_valid_d          = 1'b1;
                resp_dest_d           = req_source;
                resp_addr_d           = req_addr;
                resp_data_d           = data_q[req_idx];
                resp_mmsg_d           = MSG_EXCLUSIVE;
              end else if (line_state_q[req_idx] == LS_MS) begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                resp_dest_d  = req_source;
                resp_addr_d  = req_addr;
                resp_data_d  = data_q[req_idx];
                resp_mmsg_d  = MSG_DATA;
              end else if (line_state_q[req_idx] == LS_MEORM) begin
                // Owner must flush its copy before memory can serve readers again.
                line_state_d[req_idx] = LS_MSD;
                wait_addr_d           = req_addr;
                wait_src_d            = owner_q[req_idx];
                state_d               = ST_WAIT_WB;
              end
            end
            TX_GETM: begin
              if ((line_state_q[req_idx] == LS_MI) || (line_state_q[req_idx] == LS_MS)) begin
                line_state_d[req_idx] = LS_MEORM;
                owner_d[req_idx]      = req_source;
                state_d               = ST_RESP;
                resp_valid_d          = 1'b1;
                resp_dest_d           = req_source;
                resp_addr_d           = req_addr;
                resp_data_d           = data_q[req_idx];
                resp_mmsg_d           = MSG_DATA;
              end else if (line_state_q[req_idx] == LS_MEORM) begin
                owner_d[req_idx] = req_source;
              end
            end
            TX_PUTM: begin
              if ((line_state_q[req_idx] == LS_MEORM) && (owner_q[req_idx] == req_source)) begin
                line_state_d[req_idx] = LS_MID;
                wait_addr_d           = req_addr;
                wait_src_d            = req_source;
                state_d               = ST_WAIT_WB;
              end else begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                resp_dest_d  = req_source;
                resp_addr_d  = req_addr;
                resp_data_d  = '0;
                resp_mmsg_d  = MSG_NODATA;
              end
            end
            default: ;
          endcase
        end
      end

      ST_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end

      ST_WAIT_WB: begin
        if (wb_match) begin
          data_d[wait_idx] = wb_data;
          if (line_state_q[wait_idx] == LS_MID) begin
            line_state_d[wait_idx] = LS_MI;
            state_d                = ST_RESP;
            resp_valid_d           = 1'b1;
            resp_dest_d            = wait_src_q;
            resp_addr_d            = wait_addr_q;
            resp_data_d            = '0;
            resp_mmsg_d            = MSG_NODATAE;
          end else begin
            if (line_state_q[wait_idx] == LS_MSD) begin
              line_state_d[wait_idx] = LS_MS;
            end
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    any_meormd = 1'b0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (line_state_q[i] == LS_MEORMD) begin
        any_meormd = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      for (int i = 0; i < NUM_LINES; i++) begin
        line_state_q[i] <= LS_MI;
        owner_q[i]      <= '0;
        data_q[i]       <= '0;
      end
      resp_valid_q <= 1'b0;
      resp_dest_q  <= '0;
      resp_addr_q  <= '0;
      resp_data_q  <= '0;
      resp_mmsg_q  <= MSG_NODATA;
      wait_addr_q  <= '0;
      wait_src_q   <= '0;
    end else begin
      state_q      <= state_d;
      line_state_q <= line_state_d;
      owner_q      <= owner_d;
      data_q       <= data_d;
      resp_valid_q <= resp_valid_d;
      resp_dest_q  <= resp_dest_d;
      resp_addr_q  <= resp_addr_d;
      resp_data_q  <= resp_data_d;
      resp_mmsg_q  <= resp_mmsg_d;
      wait_addr_q  <= wait_addr_d;
      wait_src_q   <= wait_src_d;
    end
  end

  // The reserved owner-delay state has no entry path; seeing it means corruption.
  meormd_never_entered: assert property (@(posedge clk) disable iff (!rst_n) !any_meormd);

endmodule

// File: tb/tb_mem_coherence_responder.sv
// Directed scoreboard bench for mem_coherence_responder: expected responses are
// queued as requests are driven and compared when the responder emits them.
module tb_mem_coherence_responder;

  localparam int SW = 4;

  localparam logic [1:0] TX_GETS = 2'd0;
  localparam logic [1:0] TX_GETM = 2'd1;
  localparam logic [1:0] TX_PUTM = 2'd2;
  localparam logic [1:0] TX_IDLE = 2'd3;

  localparam logic [1:0] MSG_EXCLUSIVE = 2'd0;
  localparam logic [1:0] MSG_DATA      = 2'd1;
  localparam logic [1:0] MSG_NODATA    = 2'd2;
  localparam logic [1:0] MSG_NODATAE   = 2'd3;

  typedef struct packed {
    logic [SW-1:0] dest;
    logic [31:0]   addr;
    logic [7:0]    data;
    logic [1:0]    mmsg;
  } resp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [SW-1:0] req_source = '0;
  logic [31:0]   req_addr = '0;
  logic [1:0]    req_bus_tx = TX_IDLE;
  logic          wb_valid = 1'b0;
  logic          wb_memory_flag = 1'b0;
  logic [SW-1:0] wb_source = '0;
  logic [31:0]   wb_addr = '0;
  logic [7:0]    wb_data = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [SW-1:0] resp_destination;
  logic [31:0]   resp_addr;
  logic [7:0]    resp_data;
  logic [1:0]    resp_mmsg;

  resp_t expQ[$];
  int    testsRun = 0;
  int    testsFailed = 0;

  always #5 clk = ~clk;

  mem_coherence_responder #(
    .NUM_CACHE(8), .XLEN(32), .CACHELINE_SIZE(8), .NUM_LINES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_source(req_source),
    .req_addr(req_addr), .req_bus_tx(req_bus_tx),
    .wb_valid(wb_valid), .wb_memory_flag(wb_memory_flag), .wb_source(wb_source),
    .wb_addr(wb_addr), .wb_data(wb_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_destination(resp_destination), .resp_addr(resp_addr),
    .resp_data(resp_data), .resp_mmsg(resp_mmsg)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic pushExp(input logic [SW-1:0] dest, input logic [31:0] addr,
                         input logic [7:0] data, input logic [1:0] mmsg);
    resp_t r;
    r.dest = dest; r.addr = addr; r.data = data; r.mmsg = mmsg;
    expQ.push_back(r);
  endtask

  // Drives one bus request; returns just after the accepting edge.
  task automatic applyStimulus(input string tag, input logic [SW-1:0] src,
                               input logic [31:0] addr, input logic [1:0] tx);
    req_valid = 1'b1; req_source = src; req_addr = addr; req_bus_tx = tx;
    @(negedge clk);
    checkOutput({tag, "_ready"}, req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_bus_tx = TX_IDLE;
  endtask

  task automatic sendWb(input logic [SW-1:0] src, input logic flag,
                        input logic [31:0] addr, input logic [7:0] data);
    wb_valid = 1'b1; wb_memory_flag = flag; wb_source = src; wb_addr = addr; wb_data = data;
    @(posedge clk); #1;
    wb_valid = 1'b0; wb_memory_flag = 1'b0;
  endtask

  // Waits (bounded) for a response, pops the scoreboard and compares all fields.
  task automatic collectResp(input string tag);
    resp_t r;
    bit    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (resp_valid && resp_ready) found = 1'b1;
    end
    if (!found) begin
      checkOutput({tag, "_timeout"}, resp_valid, 1'b1);
    end else begin
      checkOutput({tag, "_sb_nonempty"}, expQ.size() != 0, 1'b1);
      if (expQ.size() != 0) begin
        r = expQ.pop_front();
        checkOutput({tag, "_dest"}, resp_destination, r.dest);
        checkOutput({tag, "_addr"}, resp_addr, r.addr);
        checkOutput({tag, "_data"}, resp_data, r.data);
        checkOutput({tag, "_mmsg"}, resp_mmsg, r.mmsg);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outputs",
                {resp_valid, req_ready, resp_destination, resp_mmsg, resp_addr, resp_data},
                {1'b0, 1'b0, 4'd0, MSG_NODATA, 32'd0, 8'd0});
    rst_n = 1'b1;
    #1;
    checkOutput("ready_after_reset", req_ready, 1'b1);

    // GETS on MI line grants exclusive ownership
    pushExp(4'd2, 32'h1, 8'h00, MSG_EXCLUSIVE);
    applyStimulus("gets_mi", 4'd2, 32'h1, TX_GETS);
    checkOutput("gets_mi_resp_next_cycle", {resp_valid, req_ready}, 2'b10);
    collectResp("gets_mi");

    // IDLE bus transaction is dropped
    applyStimulus("tx_idle", 4'd3, 32'h1, TX_IDLE);
    checkOutput("tx_idle_no_effect", {resp_valid, req_ready}, 2'b01);

    // GETS on owned line waits for the owner's flush
    applyStimulus("gets_meorm", 4'd5, 32'h1, TX_GETS);
    checkOutput("gets_meorm_wait", {resp_valid, req_ready}, 2'b00);
    sendWb(4'd2, 1'b0, 32'h1, 8'hEE);
    checkOutput("wb_flag0_ignored", req_ready, 1'b0);
    sendWb(4'd2, 1'b1, 32'h11, 8'hEE);
    checkOutput("wb_upper_addr_ignored", req_ready, 1'b0);
    sendWb(4'd2, 1'b1, 32'h1, 8'hA5);
    checkOutput("wb_flush_done", {resp_valid, req_ready}, 2'b01);
    pushExp(4'd6, 32'h1, 8'hA5, MSG_DATA);
    applyStimulus("gets_ms", 4'd6, 32'h1, TX_GETS);
    collectResp("gets_ms");

    // Bring line 2 to MS with data 0x11
    pushExp(4'd1, 32'h2, 8'h00, MSG_EXCLUSIVE);
    applyStimulus("gets_l2", 4'd1, 32'h2, TX_GETS);
    collectResp("gets_l2");
    applyStimulus("gets_l2_share", 4'd7, 32'h2, TX_GETS);
    sendWb(4'd1, 1'b1, 32'h2, 8'h11);
    checkOutput("l2_shared", req_ready, 1'b1);

    // GETM on MS, GETM on MEORM (owner transfer), stale PUTM
    pushExp(4'd3, 32'h2, 8'h11, MSG_DATA);
    applyStimulus("getm_ms", 4'd3, 32'h2, TX_GETM);
    collectResp("getm_ms");
    applyStimulus("getm_meorm", 4'd4, 32'h2, TX_GETM);
    checkOutput("getm_meorm_no_resp", {resp_valid, req_ready}, 2'b01);
    pushExp(4'd3, 32'h2, 8'h00, MSG_NODATA);
    applyStimulus("putm_stale", 4'd3, 32'h2, TX_PUTM);
    collectResp("putm_stale");

    // Owner PUTM, wrong-sender wb, then matching wb with a stalled request and backpressure
    applyStimulus("putm_owner", 4'd4, 32'h2, TX_PUTM);
    checkOutput("putm_owner_wait", {resp_valid, req_ready}, 2'b00);
    sendWb(4'd1, 1'b1, 32'h2, 8'hFF);
    checkOutput("wb_wrong_src_ignored", req_ready, 1'b0);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_source = 4'd0; req_addr = 32'h3; req_bus_tx = TX_GETS;
    pushExp(4'd4, 32'h2, 8'h00, MSG_NODATAE);
    wb_valid = 1'b1; wb_memory_flag = 1'b1; wb_source = 4'd4; wb_addr = 32'h2; wb_data = 8'h3C;
    @(negedge clk);
    checkOutput("req_stalled_during_wb", req_ready, 1'b0);
    @(posedge clk); #1;
    wb_valid = 1'b0; wb_memory_flag = 1'b0; req_valid = 1'b0; req_bus_tx = TX_IDLE;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput($sformatf("backpressure_hold_%0d", c),
                  {resp_valid, req_ready, resp_destination, resp_mmsg, resp_addr, resp_data},
                  {1'b1, 1'b0, 4'd4, MSG_NODATAE, 32'h2, 8'h00});
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    collectResp("putm_ack");
    checkOutput("after_ack_idle", {resp_valid, req_ready}, 2'b01);
    pushExp(4'd5, 32'h2, 8'h3C, MSG_EXCLUSIVE);
    applyStimulus("gets_after_wb", 4'd5, 32'h2, TX_GETS);
    collectResp("gets_after_wb");

    // Reset while waiting for a flush
    applyStimulus("gets_before_reset", 4'd6, 32'h2, TX_GETS);
    checkOutput("wait_before_reset", req_ready, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_outputs",
                {resp_valid, req_ready, resp_destination, resp_mmsg, resp_addr, resp_data},
                {1'b0, 1'b0, 4'd0, MSG_NODATA, 32'd0, 8'd0});
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checkOutput("ready_after_midreset", req_ready, 1'b1);
    pushExp(4'd6, 32'h2, 8'h00, MSG_EXCLUSIVE);
    applyStimulus("gets_l2_after_reset", 4'd6, 32'h2, TX_GETS);
    collectResp("gets_l2_after_reset");
    pushExp(4'd2, 32'h1, 8'h00, MSG_EXCLUSIVE);
    applyStimulus("gets_l1_after_reset", 4'd2, 32'h1, TX_GETS);
    collectResp("gets_l1_after_reset");

    checkOutput("sb_drained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/mem_coherence_responder.md
Name: mem_coherence_responder

Overview:
- Memory-side endpoint of the snooping coherence protocol: accepts bus requests (GETS/GETM/PUTM), keeps per-line memory state (MI/MS/MEORM plus delay states) and owner ID, and issues response messages to requesting caches.
- Holds the backing store for NUM_LINES lines.
- Sits between the shared request bus and the response network, one instance per memory bank.

Parameters:
- NUM_CACHE, 8, number of cache requestors; source/destination width SW = $clog2(NUM_CACHE)+1 = 4.
- XLEN, 32, address width.
- CACHELINE_SIZE, 8, line data width in bits.
- NUM_LINES, 4, backing-store lines; index = addr[$clog2(NUM_LINES)-1:0].

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  bus request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_source  in  SW  requesting cache ID.
- req_addr  in  XLEN  line address.
- req_bus_tx  in  2  0=GETS, 1=GETM, 2=PUTM, 3=IDLE.
- wb_valid  in  1  owner data message present.
- wb_memory_flag  in  1  message targets memory; ignored when 0.
- wb_source  in  SW  sender ID.
- wb_addr  in  XLEN  line address of data.
- wb_data  in  CACHELINE_SIZE  line data.
- resp_valid  out  1  response present.
- resp_ready  in  1  response consumer accepts.
- resp_destination  out  SW  requestor ID.
- resp_addr  out  XLEN  echoed request address.
- resp_data  out  CACHELINE_SIZE  line data (0 for NODATA/NODATAE).
- resp_mmsg  out  2  0=EXCLUSIVE, 1=DATA, 2=NODATA, 3=NODATAE.

Behaviour:
- Reset (async, rst_n=0): all lines state MI, owner 0, data 0; FSM IDLE; resp_valid=0, resp_destination=0, resp_addr=0, resp_data=0, resp_mmsg=NODATA (2); req_ready=0 while rst_n=0, 1 in first cycle after release.
- Control FSM, one transaction outstanding: IDLE, RESP, WAIT_WB.
- req_ready = (FSM==IDLE). Request accepted on req_valid & req_ready; IDLE (3) accepted and dropped, no state change.
- Per-line actions on acceptance (line L = index):
  - GETS, MI: resp EXCLUSIVE + data; L->MEORM, owner=source.
  - GETS, MS: resp DATA + data; stays MS.
  - GETS, MEORM: no resp; L->MSD; go WAIT_WB, expect owner.
  - GETM, MI or MS: resp DATA + data; L->MEORM, owner=source.
  - GETM, MEORM: no resp (owner supplies cache-to-cache); owner=source; stays MEORM; FSM stays IDLE.
  - PUTM, MEORM with source==owner: L->MID; go WAIT_WB, expect source.
  - PUTM, otherwise (stale): resp NODATA to source; state unchanged.
- Response timing: resp_valid rises the cycle after acceptance (FSM RESP). Fields are stable while resp_valid & !resp_ready. Transfer on resp_valid & resp_ready returns to IDLE the next cycle.
- WAIT_WB:
  - Accepts only wb_valid & wb_memory_flag & wb_source==expected & wb_addr==latched addr; all other wb traffic ignored.
  - On match: data[L]=wb_data.
  - MSD -> MS, back to IDLE, no response.
  - MID -> MI, go RESP with NODATAE ack to PUTM source, resp_data=0.
- wb_valid in IDLE/RESP: ignored.
- MEORMD is reserved and never entered; reaching it is an assertion failure.
- Address bits above the index are not compared except wb_addr vs latched addr (full XLEN compare).
- Simultaneous req_valid and wb match in WAIT_WB: wb handled, request stalled (req_ready=0).
- Reset mid-transaction: pending response dropped, all lines return to MI.

Test Plan:
- Reset, then GETS src=2 addr=0x1 -> next cycle resp_valid=1, dest=2, mmsg=EXCLUSIVE(0), data=0x00; line1=MEORM, owner=2.
- After above, GETS src=5 addr=0x1 -> no resp, req_ready=0. Then wb src=2 flag=1 addr=0x1 data=0xA5 -> line1=MS, req_ready=1. GETS src=6 addr=0x1 -> resp DATA, data=0xA5.
- GETM src=3 on MS line2 -> resp DATA to 3; then GETM src=4 -> no resp, owner=4; PUTM src=3 -> resp NODATA(2) to 3, state MEORM unchanged.
- PUTM src=4 on line2 (owner 4); wb src=1 addr=0x2 (wrong sender) ignored; wb src=4 data=0x3C -> resp NODATAE(3) to 4; line2=MI; later GETS returns EXCLUSIVE with 0x3C.
- Response backpressure: resp_ready=0 for 5 cycles -> resp fields stable, req_ready=0 throughout; transfer on cycle 6.
- rst_n pulled low during WAIT_WB -> outputs reset immediately; all lines MI; after release, GETS returns EXCLUSIVE with data 0x00.
